// File: rtl/axil_cmd_master_if.sv
`default_nettype none
// ============================================================================
// Module   : axil_cmd_master_if
// Brief    : Command/response stream plus AXI4-Lite master channel bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface axil_cmd_master_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [31:0]           cmd_wdata;
    logic [3:0]            cmd_wstrb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_write;
    logic [31:0]           rsp_rdata;
    logic [1:0]            rsp_resp;
    logic                  timeout;

    logic [ADDR_WIDTH-1:0] axi_awaddr;
    logic                  axi_awvalid;
    logic                  axi_awready;
    logic [31:0]           axi_wdata;
    logic [3:0]            axi_wstrb;
    logic                  axi_wvalid;
    logic                  axi_wready;
    logic [1:0]            axi_bresp;
    logic                  axi_bvalid;
    logic                  axi_bready;
    logic [ADDR_WIDTH-1:0] axi_araddr;
    logic                  axi_arvalid;
    logic                  axi_arready;
    logic [31:0]           axi_rdata;
    logic [1:0]            axi_rresp;
    logic                  axi_rvalid;
    logic                  axi_rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
               axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready,
               axi_rdata, axi_rresp, axi_rvalid,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, timeout,
               axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid,
               axi_bready, axi_araddr, axi_arvalid, axi_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
               axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready,
               axi_rdata, axi_rresp, axi_rvalid,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, timeout,
               axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid,
               axi_bready, axi_araddr, axi_arvalid, axi_rready
    );
endinterface
`default_nettype wire

// File: rtl/axil_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : axil_cmd_master
// Brief    : Single-outstanding AXI4-Lite initiator driven by a command stream.
// Revision : 1.0 - initial release
// ============================================================================
module axil_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  wire               clock,
    input  wire               reset,
    axil_cmd_master_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_AW_W = 3'd1;
    localparam logic [2:0] S_WR_B    = 3'd2;
    localparam logic [2:0] S_RD_AR   = 3'd3;
    localparam logic [2:0] S_RD_R    = 3'd4;
    localparam logic [2:0] S_RSP     = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  aw_pend_q, aw_pend_d;
    logic                  w_pend_q, w_pend_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic w_accept;
    logic w_wait;
    logic w_aw_done;
    logic w_w_done;

    assign w_accept  = (state_q == S_IDLE) && bus.cmd_valid;
    assign w_wait    = (state_q == S_WR_AW_W) || (state_q == S_WR_B) ||
                       (state_q == S_RD_AR)   || (state_q == S_RD_R);
    // A channel is done once its valid has dropped or it handshakes this cycle.
    assign w_aw_done = !aw_pend_q || bus.axi_awready;
    assign w_w_done  = !w_pend_q  || bus.axi_wready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.cmd_valid) state_d = bus.cmd_write ? S_WR_AW_W : S_RD_AR;
            S_WR_AW_W: if (w_aw_done && w_w_done) state_d = S_WR_B;
            S_WR_B:    if (bus.axi_bvalid) state_d = S_RSP;
            S_RD_AR:   if (bus.axi_arready) state_d = S_RD_R;
            S_RD_R:    if (bus.axi_rvalid) state_d = S_RSP;
            S_RSP:     if (bus.rsp_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_pend_d   = aw_pend_q;
        w_pend_d    = w_pend_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        cnt_d       = cnt_q;

        if (w_accept) begin
            addr_d    = bus.cmd_addr;
            wdata_d   = bus.cmd_wdata;
            wstrb_d   = bus.cmd_wstrb;
            aw_pend_d = bus.cmd_write;
            w_pend_d  = bus.cmd_write;
            cnt_d     = '0;
        end

        if (state_q == S_WR_AW_W) begin
            if (aw_pend_q && bus.axi_awready) aw_pend_d = 1'b0;
            if (w_pend_q && bus.axi_wready)   w_pend_d  = 1'b0;
        end

        if (state_q == S_WR_B && bus.axi_bvalid) begin
            rsp_write_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_resp_d  = bus.axi_bresp;
        end

        if (state_q == S_RD_R && bus.axi_rvalid) begin
            rsp_write_d = 1'b0;
            rsp_rdata_d = bus.axi_rdata;
            rsp_resp_d  = bus.axi_rresp;
        end

        // Saturating count; reaching the limit is itself the sticky timeout.
        if (w_wait && cnt_q != c_timeout) begin
            cnt_d = cnt_q + c_one;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_pend_q   <= 1'b0;
            w_pend_q    <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            cnt_q       <= '0;
        end else begin
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_pend_q   <= aw_pend_d;
            w_pend_q    <= w_pend_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        bus.cmd_ready   = (state_q == S_IDLE);
        bus.rsp_valid   = (state_q == S_RSP);
        bus.rsp_write   = rsp_write_q;
        bus.rsp_rdata   = rsp_rdata_q;
        bus.rsp_resp    = rsp_resp_q;
        bus.timeout     = (cnt_q == c_timeout);
        bus.axi_awaddr  = addr_q;
        bus.axi_awvalid = aw_pend_q;
        bus.axi_wdata   = wdata_q;
        bus.axi_wstrb   = wstrb_q;
        bus.axi_wvalid  = w_pend_q;
        bus.axi_bready  = (state_q == S_WR_B);
        bus.axi_araddr  = addr_q;
        bus.axi_arvalid = (state_q == S_RD_AR);
        bus.axi_rready  = (state_q == S_RD_R);
    end
endmodule
`default_nettype wire

// File: tb/tb_axil_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_cmd_master
// Brief    : Directed scoreboard bench for the AXI4-Lite command master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_cmd_master;
    localparam int ADDR_WIDTH     = 32;
    localparam int TIMEOUT_CYCLES = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axil_cmd_master_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    axil_cmd_master #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Response scoreboard: pops one expectation per accepted response.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected: got response write=%0b rdata=0x%08h resp=%0d with none expected",
                         bus.rsp_write, bus.rsp_rdata, bus.rsp_resp);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_write", 32'(bus.rsp_write), 32'(mon_e.wr));
                check("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                check("rsp_resp",  32'(bus.rsp_resp), 32'(mon_e.resp));
            end
        end
    end

    task automatic push_exp(input logic wr, input logic [31:0] rd, input logic [1:0] rs);
        rsp_t e;
        e.wr = wr; e.rdata = rd; e.resp = rs;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_wstrb = s;
    endtask

    // All-ready write: command in cycle 0, AW+W cycle 1, B cycle 2, response cycle 3.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] br);
        step();
        check("wr_cmd_ready", 32'(bus.cmd_ready), 1);
        issue(1'b1, a, d, s);
        bus.axi_awready = 1'b1; bus.axi_wready = 1'b1;
        bus.axi_bvalid  = 1'b1; bus.axi_bresp  = br;
        bus.rsp_ready   = 1'b1;
        push_exp(1'b1, 32'h0, br);
        step();
        bus.cmd_valid = 1'b0;
        check("wr_c1_awvalid", 32'(bus.axi_awvalid), 1);
        check("wr_c1_wvalid",  32'(bus.axi_wvalid), 1);
        check("wr_c1_awaddr",  bus.axi_awaddr, a);
        check("wr_c1_wdata",   bus.axi_wdata, d);
        check("wr_c1_wstrb",   32'(bus.axi_wstrb), 32'(s));
        check("wr_c1_bready",  32'(bus.axi_bready), 0);
        step();
        check("wr_c2_awvalid", 32'(bus.axi_awvalid), 0);
        check("wr_c2_wvalid",  32'(bus.axi_wvalid), 0);
        check("wr_c2_bready",  32'(bus.axi_bready), 1);
        step();
        check("wr_c3_rsp_valid", 32'(bus.rsp_valid), 1);
        check("wr_c3_bready",    32'(bus.axi_bready), 0);
        bus.axi_bvalid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] rd, input logic [1:0] rr);
        step();
        check("rd_cmd_ready", 32'(bus.cmd_ready), 1);
        issue(1'b0, a, 32'h0, 4'h0);
        bus.axi_arready = 1'b1;
        bus.axi_rvalid  = 1'b1; bus.axi_rdata = rd; bus.axi_rresp = rr;
        bus.rsp_ready   = 1'b1;
        push_exp(1'b0, rd, rr);
        step();
        bus.cmd_valid = 1'b0;
        check("rd_c1_arvalid", 32'(bus.axi_arvalid), 1);
        check("rd_c1_araddr",  bus.axi_araddr, a);
        check("rd_c1_awvalid", 32'(bus.axi_awvalid), 0);
        check("rd_c1_timeout", 32'(bus.timeout), 0);
        step();
        check("rd_c2_arvalid", 32'(bus.axi_arvalid), 0);
        check("rd_c2_rready",  32'(bus.axi_rready), 1);
        step();
        check("rd_c3_rsp_valid", 32'(bus.rsp_valid), 1);
        check("rd_c3_rready",    32'(bus.axi_rready), 0);
        bus.axi_rvalid = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0;   bus.cmd_wstrb = '0;   bus.rsp_ready = 1'b0;
        bus.axi_awready = 1'b0; bus.axi_wready = 1'b0;
        bus.axi_bresp = 2'b00;  bus.axi_bvalid = 1'b0;
        bus.axi_arready = 1'b0; bus.axi_rdata = '0;
        bus.axi_rresp = 2'b00;  bus.axi_rvalid = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_valids",    32'({bus.axi_awvalid, bus.axi_wvalid, bus.axi_arvalid,
                                    bus.axi_bready, bus.axi_rready, bus.rsp_valid}), 0);
        check("rst_timeout",   32'(bus.timeout), 0);
        check("rst_awaddr",    bus.axi_awaddr, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        do_write(32'h10, 32'hA5A5A5A5, 4'hF, 2'b00);
        do_read(32'h20, 32'h12341234, 2'b00);

        // Write with immediate wready and awready delayed three cycles.
        step();
        issue(1'b1, 32'h44, 32'hDEADBEEF, 4'h3);
        bus.axi_awready = 1'b0; bus.axi_wready = 1'b1;
        bus.axi_bvalid  = 1'b1; bus.axi_bresp  = 2'b00;
        bus.rsp_ready   = 1'b1;
        push_exp(1'b1, 32'h0, 2'b00);
        for (int i = 1; i <= 4; i++) begin
            step();
            bus.cmd_valid = 1'b0;
            check("dly_awvalid", 32'(bus.axi_awvalid), 1);
            check("dly_awaddr",  bus.axi_awaddr, 32'h44);
            check("dly_wvalid",  32'(bus.axi_wvalid), (i == 1) ? 1 : 0);
            check("dly_bready",  32'(bus.axi_bready), 0);
            if (i == 4) bus.axi_awready = 1'b1;
        end
        step();
        bus.axi_awready = 1'b0;
        check("dly_c5_awvalid", 32'(bus.axi_awvalid), 0);
        check("dly_c5_bready",  32'(bus.axi_bready), 1);
        step();
        check("dly_c6_rsp_valid", 32'(bus.rsp_valid), 1);
        bus.axi_bvalid = 1'b0;

        do_write(32'h14, 32'h00000001, 4'h1, 2'b10);
        do_read(32'h24, 32'h55AA55AA, 2'b11);

        // Response back-pressure for five cycles.
        step();
        issue(1'b0, 32'h30, 32'h0, 4'h0);
        bus.axi_arready = 1'b1;
        bus.axi_rvalid  = 1'b1; bus.axi_rdata = 32'hCAFEF00D; bus.axi_rresp = 2'b01;
        bus.rsp_ready   = 1'b0;
        push_exp(1'b0, 32'hCAFEF00D, 2'b01);
        step();
        bus.cmd_valid = 1'b0;
        step();
        step();
        bus.axi_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            check("bp_rsp_valid", 32'(bus.rsp_valid), 1);
            check("bp_rsp_rdata", bus.rsp_rdata, 32'hCAFEF00D);
            check("bp_rsp_write", 32'(bus.rsp_write), 0);
            check("bp_rsp_resp",  32'(bus.rsp_resp), 1);
            check("bp_cmd_ready", 32'(bus.cmd_ready), 0);
        end
        step();
        bus.rsp_ready = 1'b1;
        check("bp_rsp_valid_release", 32'(bus.rsp_valid), 1);
        step();
        check("bp_cmd_ready_after", 32'(bus.cmd_ready), 1);
        check("bp_rsp_valid_after", 32'(bus.rsp_valid), 0);

        // Slow read slave: timeout rises after TIMEOUT_CYCLES stalled cycles.
        step();
        issue(1'b0, 32'h50, 32'h0, 4'h0);
        bus.axi_arready = 1'b1;
        bus.axi_rvalid  = 1'b0;
        bus.rsp_ready   = 1'b1;
        push_exp(1'b0, 32'h0BADF00D, 2'b00);
        step();
        bus.cmd_valid = 1'b0;
        check("to_c1_timeout", 32'(bus.timeout), 0);
        for (int c = 2; c <= 21; c++) begin
            step();
            check("to_wait_timeout", 32'(bus.timeout), (c >= 17) ? 1 : 0);
            if (c == 21) begin
                bus.axi_rvalid = 1'b1; bus.axi_rdata = 32'h0BADF00D; bus.axi_rresp = 2'b00;
            end
        end
        step();
        bus.axi_rvalid = 1'b0;
        check("to_rsp_valid",   32'(bus.rsp_valid), 1);
        check("to_rsp_timeout", 32'(bus.timeout), 1);
        do_read(32'h54, 32'h13579BDF, 2'b00);

        // Asynchronous reset while arvalid is asserted.
        step();
        issue(1'b0, 32'h60, 32'h0, 4'h0);
        bus.axi_arready = 1'b0;
        bus.axi_rvalid  = 1'b0;
        bus.rsp_ready   = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        check("rr_arvalid_before", 32'(bus.axi_arvalid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rr_arvalid_async", 32'(bus.axi_arvalid), 0);
        check("rr_cmd_ready_async", 32'(bus.cmd_ready), 1);
        check("rr_araddr_async", bus.axi_araddr, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_rsp_valid", 32'(bus.rsp_valid), 0);
            check("rr_cmd_ready", 32'(bus.cmd_ready), 1);
            check("rr_arvalid",   32'(bus.axi_arvalid), 0);
        end

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
